// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
// Stage occupancy states, the RV32I NOP bubble and common stage payload bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and bubble insertion on empty.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(RV_NOP),
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and data is held stable while valid & !ready.

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = {state_q == FULL, state_q == ONE};

  // With the skid buffer in_ready is a pure function of state, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready = SKID ? (state_q != FULL) : (!out_valid || out_ready);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            // Only reachable with the skid buffer; single-entry in_ready forbids it.
            if (SKID) begin
              state_d = FULL;
              skid_d  = in_data;
            end
          end else if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: scoreboard-checked SKID=1 instance
// plus directed checks on a SKID=0 instance.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;

  logic        v0, ir0, f0, ov0, or0;
  logic [31:0] d0, od0;
  logic [1:0]  c0;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  pipe_skid_stage #(.DATA_W(32), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  pipe_skid_stage #(.DATA_W(32), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0),
    .in_data(d0), .flush(f0), .out_valid(ov0),
    .out_ready(or0), .out_data(od0), .count(c0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // driver: inputs change 1 time unit after a rising edge; the model is
  // updated after the following falling edge, once in_ready is known.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    #1;
    if (rst && f) exp_q.delete();
    else if (rst && v && in_ready) exp_q.push_back(d);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    check("count", 32'(count), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() != 0) check("head_data", out_data, exp_q[0]);
    else check("bubble_data", out_data, 32'h0000_0013);
    if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    v0 = 1'b0; d0 = '0; or0 = 1'b0; f0 = 1'b0;

    // reset held with random inputs
    for (int i = 0; i < 5; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0000_0013);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_in_ready_skid0", 32'(ir0), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // first push latency
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("latency_data", out_data, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // streaming
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_drained", 32'(count), 32'd0);

    // backpressure
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    check("bp_count_full", 32'(count), 32'd2);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_head_a", out_data, 32'hAAAA_0001);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_head_b", out_data, 32'hBBBB_0002);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_empty", 32'(count), 32'd0);

    // flush with a competing push
    drive(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h2222_0002, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("fl_count_before", 32'(count), 32'd2);
    drive(1'b1, 32'h0000_0055, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_data", out_data, 32'h0000_0013);
    check("fl_count", 32'(count), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // reset in the middle of a transfer
    drive(1'b1, 32'h7777_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h7777_0002, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // single-entry variant
    @(posedge clk);
    #1; v0 = 1'b1; d0 = 32'h0000_00A0; or0 = 1'b0;
    #1 check("s0_ready_empty", 32'(ir0), 32'd1);
    @(posedge clk);
    #1 v0 = 1'b0;
    #1;
    check("s0_valid", 32'(ov0), 32'd1);
    check("s0_data_a0", od0, 32'h0000_00A0);
    check("s0_ready_stall", 32'(ir0), 32'd0);
    or0 = 1'b1;
    #1 check("s0_ready_comb", 32'(ir0), 32'd1);
    v0 = 1'b1; d0 = 32'h0000_00A1;
    @(posedge clk);
    #1; v0 = 1'b0; or0 = 1'b0;
    #1;
    check("s0_data_a1", od0, 32'h0000_00A1);
    check("s0_count_passthru", 32'(c0), 32'd1);
    or0 = 1'b1;
    @(posedge clk);
    #2;
    check("s0_count_empty", 32'(c0), 32'd0);
    check("s0_bubble", od0, 32'h0000_0013);
    or0 = 1'b0;

    // random traffic
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
